// File: rtl/top_pkg.sv
// top_pkg: shared types and constants for the SPI flash reader.
// Holds the transaction FSM encoding and the READ command fields.
package top_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_SHIFT,
      ST_STOP
   } state_t;

   localparam logic [7:0]  RD_OPCODE  = 8'h03;
   localparam logic [23:0] START_ADDR = 24'h000000;

endpackage

// File: rtl/top_spi_master.sv
// spi_master: mode-0 SPI READ engine (clock divider, shifter, CS_n).
// Sends opcode + address, then clocks in RD_BYTES bytes MSB first.
module spi_master
   import top_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int RD_BYTES = 4
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_miso,
   output logic        o_sclk,
   output logic        o_mosi,
   output logic        o_cs_n,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rx
);

   localparam int NBITS = 32 + 8 * RD_BYTES;
   localparam int DW    = $clog2(CLK_DIV + 1);
   localparam int BW    = $clog2(NBITS);
   localparam int PAD   = 32 - 8 * RD_BYTES;

   state_t        r_state;
   state_t        w_next;
   logic [DW-1:0] r_div;
   logic [BW-1:0] r_bit;
   logic [30:0]   r_tx;
   logic [31:0]   r_rx;
   logic          r_sclk;
   logic          r_mosi;
   logic          r_cs_n;
   logic          r_done;
   logic          w_tick;
   logic          w_last;

   assign w_tick = (r_div == DW'(CLK_DIV - 1));
   assign w_last = (r_bit == BW'(NBITS - 1));

   assign o_sclk = r_sclk;
   assign o_mosi = r_mosi;
   assign o_cs_n = r_cs_n;
   assign o_busy = (r_state != ST_IDLE);
   assign o_done = r_done;
   assign o_rx   = r_rx << PAD;

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // next state: frame ends on the falling edge after the last bit
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (i_start) w_next = ST_START;
         ST_START: if (w_tick) w_next = ST_SHIFT;
         ST_SHIFT: if (w_tick && r_sclk && w_last) w_next = ST_STOP;
         ST_STOP:  if (w_tick) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // divider, SCLK, shifters; MOSI moves only with the falling edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div  <= '0;
         r_bit  <= '0;
         r_tx   <= '0;
         r_rx   <= '0;
         r_sclk <= 1'b0;
         r_mosi <= 1'b0;
         r_cs_n <= 1'b1;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_IDLE || w_tick) r_div <= '0;
         else                              r_div <= r_div + 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_cs_n <= 1'b0;
                  r_bit  <= '0;
                  r_mosi <= RD_OPCODE[7];
                  r_tx   <= {RD_OPCODE[6:0], START_ADDR};
               end
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                     r_rx   <= {r_rx[30:0], i_miso};
                  end else begin
                     r_sclk <= 1'b0;
                     if (w_last) begin
                        r_cs_n <= 1'b1;
                        r_mosi <= 1'b0;
                        r_done <= 1'b1;
                     end else begin
                        r_bit  <= r_bit + 1'b1;
                        r_mosi <= r_tx[30];
                        r_tx   <= {r_tx[29:0], 1'b0};
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/top.sv
// top: push-button triggered SPI flash READ with debounced button.
// Define TEST_PINS_EN to mirror the SPI pins on the TEST_* probes.
module top
   import top_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int DB_CYCLES = 8,
   parameter int RD_BYTES  = 4
)(
   input  logic CLKA,
   input  logic rst_n,
   input  logic pb_sw1,
   output logic SPI_CLK,
   output logic SPI_MOSI,
   input  logic SPI_MISO,
   output logic SPI_CS_n,
   output logic TEST_CLK,
   output logic TEST_MOSI,
   output logic TEST_MISO,
   output logic TEST_CS_n,
   output logic FPGA_CLK,
   output logic MEM_CM_READY
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_db;
   logic          r_db_d;
   logic          r_fclk;
   logic [31:0]   r_rd_data;
   logic          w_trig;
   logic          w_busy;
   logic          w_done;
   logic [31:0]   w_rx;

   assign w_trig       = r_db_d & ~r_db;
   assign FPGA_CLK     = r_fclk;
   assign MEM_CM_READY = ~w_busy;

   // two-flop synchroniser, idles at the released level
   always_ff @(posedge CLKA or posedge rst_n) begin
      if (rst_n) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], pb_sw1};
   end

   // debounce: take a new level after DB_CYCLES matching samples
   always_ff @(posedge CLKA or posedge rst_n) begin
      if (rst_n) begin
         r_cnt  <= '0;
         r_db   <= 1'b1;
         r_db_d <= 1'b1;
      end else begin
         r_db_d <= r_db;
         if (r_sync[1] == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_cnt <= '0;
            r_db  <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // heartbeat at half the system clock
   always_ff @(posedge CLKA or posedge rst_n) begin
      if (rst_n) r_fclk <= 1'b0;
      else       r_fclk <= ~r_fclk;
   end

   // read data is published only once the frame completes
   always_ff @(posedge CLKA or posedge rst_n) begin
      if (rst_n)       r_rd_data <= '0;
      else if (w_done) r_rd_data <= w_rx;
   end

   spi_master #(
      .CLK_DIV  (CLK_DIV),
      .RD_BYTES (RD_BYTES)
   ) u_spi (
      .i_clk   (CLKA),
      .i_rst   (rst_n),
      .i_start (w_trig),
      .i_miso  (SPI_MISO),
      .o_sclk  (SPI_CLK),
      .o_mosi  (SPI_MOSI),
      .o_cs_n  (SPI_CS_n),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_rx    (w_rx)
   );

`ifdef TEST_PINS_EN
   assign TEST_CLK  = SPI_CLK;
   assign TEST_MOSI = SPI_MOSI;
   assign TEST_MISO = SPI_MISO;
   assign TEST_CS_n = SPI_CS_n;
`else
   assign TEST_CLK  = 1'b0;
   assign TEST_MOSI = 1'b0;
   assign TEST_MISO = 1'b0;
   assign TEST_CS_n = 1'b0;
`endif

endmodule

// File: tb/tb_top.sv
// tb_top: randomized self-checking bench for the SPI flash reader.
// Acts as the flash slave and checks every CLKA cycle against a model.
module tb_top;

   localparam int CLK_DIV   = 2;
   localparam int DB_CYCLES = 8;
   localparam int RD_BYTES  = 4;
   localparam int NBITS     = 32 + 8 * RD_BYTES;
   localparam logic [63:0] EXP_FRAME = 64'h03000000 << (8 * RD_BYTES);

   logic CLKA     = 1'b0;
   logic rst_n    = 1'b1;
   logic pb_sw1   = 1'b1;
   logic SPI_MISO = 1'b0;
   logic SPI_CLK, SPI_MOSI, SPI_CS_n;
   logic TEST_CLK, TEST_MOSI, TEST_MISO, TEST_CS_n;
   logic FPGA_CLK, MEM_CM_READY;

   int checks   = 0;
   int failures = 0;

   logic        alt_mode  = 1'b0;
   logic        alt_start = 1'b0;
   int          tx_cnt    = 0;
   int          rises     = 0;
   int          hi_cnt    = 1000;
   int          ph_len    = 0;
   logic        ph_valid  = 1'b0;
   logic        have_prev = 1'b0;
   logic        prev_cs   = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        prev_mosi = 1'b0;
   logic        prev_f    = 1'b0;
   logic [63:0] mosi_frame = '0;
   logic [63:0] miso_frame = '0;
   logic [63:0] mask;
   logic [31:0] exp_rd = '0;
   logic [3:0]  exp_test;

   top #(
      .CLK_DIV   (CLK_DIV),
      .DB_CYCLES (DB_CYCLES),
      .RD_BYTES  (RD_BYTES)
   ) dut (
      .CLKA         (CLKA),
      .rst_n        (rst_n),
      .pb_sw1       (pb_sw1),
      .SPI_CLK      (SPI_CLK),
      .SPI_MOSI     (SPI_MOSI),
      .SPI_MISO     (SPI_MISO),
      .SPI_CS_n     (SPI_CS_n),
      .TEST_CLK     (TEST_CLK),
      .TEST_MOSI    (TEST_MOSI),
      .TEST_MISO    (TEST_MISO),
      .TEST_CS_n    (TEST_CS_n),
      .FPGA_CLK     (FPGA_CLK),
      .MEM_CM_READY (MEM_CM_READY)
   );

   always #10 CLKA = ~CLKA;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // flash slave + per-cycle model of the SPI frame and status pins
   always @(negedge CLKA) begin
      if (rst_n) begin
         chk("rst_cs_n", SPI_CS_n, 1);
         chk("rst_sclk", SPI_CLK, 0);
         chk("rst_mosi", SPI_MOSI, 0);
         chk("rst_ready", MEM_CM_READY, 1);
         chk("rst_fpga_clk", FPGA_CLK, 0);
         chk("rst_rd_data", dut.r_rd_data, 0);
         exp_rd    = '0;
         hi_cnt    = 1000;
         have_prev = 1'b0;
         ph_valid  = 1'b0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b0;
         prev_mosi = 1'b0;
         prev_f    = 1'b0;
      end else begin
         if (have_prev) chk("fpga_toggle", FPGA_CLK, !prev_f);
         if (prev_cs && !SPI_CS_n) begin
            tx_cnt++;
            rises      = 0;
            mosi_frame = '0;
            miso_frame = '0;
            ph_valid   = 1'b0;
            SPI_MISO   = alt_mode ? alt_start : 1'($urandom);
         end
         if (!prev_cs && SPI_CS_n) begin
            hi_cnt = 0;
            chk("sclk_rises", rises, NBITS);
            chk("mosi_frame", mosi_frame, EXP_FRAME);
            mask   = (64'd1 << (8 * RD_BYTES)) - 64'd1;
            exp_rd = 32'((miso_frame & mask) << (32 - 8 * RD_BYTES));
         end else if (SPI_CS_n && hi_cnt < 1000) begin
            hi_cnt++;
         end
         if (SPI_CLK != prev_sclk) begin
            if (ph_valid) chk("sclk_half_period", ph_len, CLK_DIV);
            ph_valid = 1'b1;
            ph_len   = 1;
         end else begin
            ph_len++;
         end
         if (SPI_CLK && !prev_sclk) begin
            rises++;
            mosi_frame = {mosi_frame[62:0], SPI_MOSI};
            miso_frame = {miso_frame[62:0], SPI_MISO};
            chk("rise_inside_cs", SPI_CS_n, 0);
         end
         if (!SPI_CLK && prev_sclk && !SPI_CS_n)
            SPI_MISO = alt_mode ? !SPI_MISO : 1'($urandom);
         if (SPI_MOSI != prev_mosi) chk("mosi_moves_low", SPI_CLK, 0);
         if (SPI_CS_n) begin
            chk("idle_sclk", SPI_CLK, 0);
            chk("idle_mosi", SPI_MOSI, 0);
         end
         chk("ready", MEM_CM_READY, SPI_CS_n && hi_cnt >= CLK_DIV);
         if (!SPI_CS_n || hi_cnt >= CLK_DIV)
            chk("rd_data", dut.r_rd_data, exp_rd);
`ifdef TEST_PINS_EN
         exp_test = {SPI_CLK, SPI_MOSI, SPI_MISO, SPI_CS_n};
`else
         exp_test = 4'b0000;
`endif
         chk("test_pins", {TEST_CLK, TEST_MOSI, TEST_MISO, TEST_CS_n},
             exp_test);
         prev_cs   = SPI_CS_n;
         prev_sclk = SPI_CLK;
         prev_mosi = SPI_MOSI;
         prev_f    = FPGA_CLK;
         have_prev = 1'b1;
      end
   end

   task automatic press(input int len, output int lat);
      lat = -1;
      @(posedge CLKA);
      #2 pb_sw1 = 1'b0;
      for (int i = 1; i <= len; i++) begin
         @(posedge CLKA);
         #2;
         if (lat < 0 && !SPI_CS_n) lat = i;
      end
      pb_sw1 = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(posedge CLKA);
      #2;
      while (!(MEM_CM_READY && SPI_CS_n) && n < 2000) begin
         @(posedge CLKA);
         #2;
         n++;
      end
      chk("idle_timeout", n < 2000, 1);
   endtask

   task automatic settle();
      repeat (DB_CYCLES + 6) @(posedge CLKA);
      #2;
   endtask

   initial begin
      int lat;
      int n0;
      int n;
      rst_n = 1'b1;
      repeat (4) @(posedge CLKA);
      #2 rst_n = 1'b0;
      repeat (5) @(posedge CLKA);
      #2;

      alt_mode  = 1'b1;
      alt_start = 1'b0;
      n0 = tx_cnt;
      press(20, lat);
      chk("cs_fall_latency", lat > 0 && lat <= DB_CYCLES + 4, 1);
      wait_idle();
      chk("one_tx", tx_cnt, n0 + 1);
      chk("rd_alt55", dut.r_rd_data, 64'h55555555);
      chk("model_alt55", exp_rd, 64'h55555555);
      settle();

      alt_start = 1'b1;
      n0 = tx_cnt;
      press(20, lat);
      wait_idle();
      chk("one_tx", tx_cnt, n0 + 1);
      chk("rd_altAA", dut.r_rd_data, 64'hAAAAAAAA);
      chk("model_altAA", exp_rd, 64'hAAAAAAAA);
      settle();

      alt_mode = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n0 = tx_cnt;
         press($urandom_range(40, DB_CYCLES + 2), lat);
         chk("cs_fall_latency", lat > 0 && lat <= DB_CYCLES + 4, 1);
         wait_idle();
         chk("one_tx", tx_cnt, n0 + 1);
         chk("rd_random", dut.r_rd_data, exp_rd);
         settle();
      end

      for (int k = 0; k < 4; k++) begin
         n0 = tx_cnt;
         press(k == 0 ? DB_CYCLES - 2 : $urandom_range(DB_CYCLES - 2, 1), lat);
         repeat (40) @(posedge CLKA);
         #2;
         chk("glitch_no_tx", tx_cnt, n0);
         chk("glitch_cs_high", SPI_CS_n, 1);
      end

      n0 = tx_cnt;
      press(500, lat);
      chk("cs_fall_latency", lat > 0 && lat <= DB_CYCLES + 4, 1);
      wait_idle();
      settle();
      chk("hold_one_tx", tx_cnt, n0 + 1);

      n0 = tx_cnt;
      press(20, lat);
      repeat (40) @(posedge CLKA);
      press(20, lat);
      wait_idle();
      settle();
      chk("busy_press_ignored", tx_cnt, n0 + 1);

      press(20, lat);
      n = 0;
      while (rises < 20 && n < 2000) begin
         @(posedge CLKA);
         n++;
      end
      chk("reach_20_edges", n < 2000, 1);
      #3 rst_n = 1'b1;
      #1;
      chk("abort_cs_n", SPI_CS_n, 1);
      chk("abort_sclk", SPI_CLK, 0);
      chk("abort_ready", MEM_CM_READY, 1);
      chk("abort_rd_data", dut.r_rd_data, 0);
      repeat (3) @(posedge CLKA);
      #2 rst_n = 1'b0;
      n0 = tx_cnt;
      repeat (200) @(posedge CLKA);
      #2;
      chk("no_retrigger", tx_cnt, n0);
      chk("post_abort_cs", SPI_CS_n, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
